// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Requester (fetch/data) and memory-side bundle of the shared
//                memory port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              ack0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              ack1;

    logic [DATA_W-1:0] rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters plus the memory device sit on the master side.
    modport master (
        output req0, addr0, req1, we1, addr1, wdata1, mem_rdata,
        input  gnt0, ack0, gnt1, ack1, rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req0, addr0, req1, we1, addr1, wdata1, mem_rdata,
        output gnt0, ack0, gnt1, ack1, rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-requester arbiter (fetch / data) for a single-ported
//                memory. Build option MEM_ARB_ROUND_ROBIN_EN selects
//                round-robin instead of fixed priority with anti-starvation.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_ack0;
    logic              r_ack1;

    logic              w_idle;
    logic              w_pick0;
    logic              w_gnt0;
    logic              w_gnt1;

    // Grants are combinational and forced low while reset is asserted.
    assign w_idle = (r_state == ST_IDLE) && rst_n;
    assign w_gnt0 = w_idle && bus.req0 && (!bus.req1 || w_pick0);
    assign w_gnt1 = w_idle && bus.req1 && !w_gnt0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last1;

    assign w_pick0 = r_last1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last1 <= 1'b1;
        end else if (w_gnt0) begin
            r_last1 <= 1'b0;
        end else if (w_gnt1) begin
            r_last1 <= 1'b1;
        end
    end
`else
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_pick0 = (r_starve_cnt == STARVE_LIMIT);

    // Counts consecutive contested losses of the fetch port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_gnt0 || !bus.req0) begin
                r_starve_cnt <= '0;
            end else if (w_gnt1 && (r_starve_cnt != STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_state     <= ST_ACCESS;
                        r_owner     <= w_gnt1;
                        r_addr      <= w_gnt1 ? bus.addr1 : bus.addr0;
                        r_mem_read  <= !(w_gnt1 && bus.we1);
                        r_mem_write <= w_gnt1 && bus.we1;
                        if (w_gnt1) begin
                            r_wdata <= bus.wdata1;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_state     <= ST_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    if (!r_mem_write) begin
                        r_rdata <= bus.mem_rdata;
                    end
                    r_ack0 <= !r_owner;
                    r_ack1 <= r_owner;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata     = r_rdata;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Randomized bench for mem_port_arbiter with a transaction-level
//                reference model and a behavioural memory device.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Memory device: combinational read, write on rising edge, preload port.
    logic [15:0] mem [0:63];
    logic        pl_we = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    assign bus.mem_rdata = mem[bus.mem_addr[6:1]];
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bus.mem_write) mem[bus.mem_addr[6:1]] <= bus.mem_wdata;
    end

    // Requester intent
    logic        p0_req, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr, p1_wdata;

    // Reference model
    logic [15:0] ref_mem [0:63];
    bit          m_access, m_we, m_ack_v;
    int          m_owner, m_ack_owner, m_losses, m_last;
    logic [15:0] m_addr, m_wdata, m_rdata;
    int          exp_win, dut_win;
    int          total, bad;
    int          order [10];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int arbitrate(input bit r0, input bit r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return (m_last == 1) ? 0 : 1;
`else
        return (m_losses >= STARVE_MAX) ? 0 : 1;
`endif
    endfunction

    function automatic logic [15:0] rand_addr();
        return 16'($urandom_range(0, 127));
    endfunction

    task automatic model_reset();
        m_access = 0; m_we = 0; m_ack_v = 0; m_owner = 0; m_ack_owner = 0;
        m_losses = 0; m_last = 1;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt0"}, bus.gnt0, 0);
        check_eq({tag, "_gnt1"}, bus.gnt1, 0);
        check_eq({tag, "_ack0"}, bus.ack0, 0);
        check_eq({tag, "_ack1"}, bus.ack1, 0);
        check_eq({tag, "_mem_read"}, bus.mem_read, 0);
        check_eq({tag, "_mem_write"}, bus.mem_write, 0);
        check_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
        check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check_eq({tag, "_rdata"}, bus.rdata, 0);
    endtask

    // One clock cycle: drive intent, compare DUT to model, advance model.
    task automatic step(input bit glitch1 = 1'b0);
        @(negedge clk);
        bus.req0 = p0_req; bus.addr0 = p0_addr;
        bus.we1 = p1_we; bus.addr1 = p1_addr; bus.wdata1 = p1_wdata;
        if (glitch1) begin
            bus.req1 = 1'b1;
            #1;
        end
        bus.req1 = p1_req;
        #1;
        exp_win = m_access ? -1 : arbitrate(p0_req, p1_req);
        dut_win = bus.gnt1 ? 1 : (bus.gnt0 ? 0 : -1);
        check_eq("gnt0", bus.gnt0, exp_win == 0);
        check_eq("gnt1", bus.gnt1, exp_win == 1);
        check_eq("mem_read", bus.mem_read, m_access && !m_we);
        check_eq("mem_write", bus.mem_write, m_access && m_we);
        check_eq("mem_addr", bus.mem_addr, m_addr);
        if (m_access && m_we) check_eq("mem_wdata", bus.mem_wdata, m_wdata);
        check_eq("ack0", bus.ack0, m_ack_v && (m_ack_owner == 0));
        check_eq("ack1", bus.ack1, m_ack_v && (m_ack_owner == 1));
        check_eq("rdata", bus.rdata, m_rdata);

        m_ack_v = m_access;
        m_ack_owner = m_owner;
        if (m_access) begin
            if (m_we) ref_mem[m_addr[6:1]] = m_wdata;
            else      m_rdata = ref_mem[m_addr[6:1]];
        end else begin
            if (exp_win == 0 || !p0_req) m_losses = 0;
            else if (exp_win == 1 && m_losses < STARVE_MAX) m_losses++;
            if (exp_win >= 0) begin
                m_last  = exp_win;
                m_owner = exp_win;
                m_addr  = (exp_win == 1) ? p1_addr : p0_addr;
                m_we    = (exp_win == 1) && p1_we;
                if (exp_win == 1) m_wdata = p1_wdata;
            end
        end
        m_access = !m_access && (exp_win >= 0);
    endtask

    task automatic new_p0();
        p0_addr = rand_addr();
    endtask

    task automatic new_p1();
        p1_we = 1'($urandom_range(0, 1));
        p1_addr = rand_addr();
        p1_wdata = 16'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        total = 0; bad = 0;
        p0_req = 0; p1_req = 0; p1_we = 0;
        p0_addr = '0; p1_addr = '0; p1_wdata = '0;
        bus.req0 = 0; bus.addr0 = '0; bus.req1 = 0; bus.we1 = 0;
        bus.addr1 = '0; bus.wdata1 = '0;
        model_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif

        // Preload memory while reset is held.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pl_we = 1'b1;
            pl_addr = 6'(i);
            pl_data = (i == 2) ? 16'h1234 : ((i == 16) ? 16'h0000 : 16'($urandom));
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_we = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch read of word 2.
        p0_req = 1; p0_addr = 16'h0004;
        step();
        p0_req = 0;
        step();
        check_eq("t2_mem_read", bus.mem_read, 1);
        step();
        check_eq("t2_ack0", bus.ack0, 1);
        check_eq("t2_rdata", bus.rdata, 16'h1234);

        // Store then fetch the same address.
        p1_req = 1; p1_we = 1; p1_addr = 16'h0010; p1_wdata = 16'hBEEF;
        step();
        p1_req = 0;
        step();
        step();
        check_eq("t3_ack1", bus.ack1, 1);
        p0_req = 1; p0_addr = 16'h0010;
        step();
        p0_req = 0;
        step();
        step();
        check_eq("t3_rdata", bus.rdata, 16'hBEEF);

        // Reset during the write access to 0x0020.
        p1_req = 1; p1_we = 1; p1_addr = 16'h0020; p1_wdata = 16'hA5A5;
        step();
        p1_req = 0;
        @(negedge clk);
        bus.req1 = 0;
        #1;
        check_eq("t5_write_before", bus.mem_write, 1);
        bus.req0 = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_word", mem[16], 16'h0000);
        check_eq("t5_ack1", bus.ack1, 0);
        bus.req0 = 1'b0;
        rst_n = 1'b1;
        model_reset();

        // Both ports held requesting: grant order.
        n = 0;
        p0_req = 1; p1_req = 1; new_p0(); new_p1();
        for (int c = 0; c < 40 && n < 10; c++) begin
            step();
            if (dut_win >= 0) begin
                check_eq("order", dut_win, order[n]);
                n++;
            end
            if (exp_win == 0) new_p0();
            if (exp_win == 1) new_p1();
        end
        check_eq("order_count", n, 10);

        // Data request glitches high and drops in the cycle fetch wins.
        p1_req = 0;
        if (m_access) step();
        step(1'b1);
        check_eq("t6_win", dut_win, 0);
        p0_req = 0;
        step();
        step();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            step();
            if (exp_win == 0) p0_req = 0;
            if (exp_win == 1) p1_req = 0;
            if (!p0_req && $urandom_range(0, 1) == 1) begin
                p0_req = 1; new_p0();
            end
            if (p1_req && $urandom_range(0, 19) == 0) begin
                p1_req = 0;
            end else if (!p1_req && $urandom_range(0, 1) == 1) begin
                p1_req = 1; new_p1();
            end
        end
        p0_req = 0; p1_req = 0;
        for (int c = 0; c < 4; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
